spi_poll_sched: RTL and testbench

Scheduler that sequences the 5-byte SPI receive controller by generating its ce strobe with correct frame timing.
- Inserts the SS setup delay, per-bit spacing and inter-byte gaps the peripheral needs, and repeats the frame at a fixed poll rate.
- After each frame it captures the receiver's 40-bit DOUT, decodes X/Y/buttons, and pulses frame_valid.
- Monitors SS to detect desync and resets the receiver when it sees one.

---
 rtl/spi_poll_pkg.sv | 43 ++++
 rtl/jstk_frame_decode.sv | 49 ++++
 rtl/spi_poll_sched.sv | 171 +++++++++++++++++
 tb/tb_spi_poll_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_poll_pkg.sv
// spi_poll_pkg: shared types and constants for the SPI poll scheduler.
// Holds the FSM state enum, frame geometry, and the bit positions used to
// decode the 40-bit joystick frame into X, Y and buttons.
package spi_poll_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      BIT,
      FINISH,
      CAPTURE,
      RESYNC
   } state_e;

   localparam int FRAME_BITS = 40;
   localparam int BYTE_BITS  = 8;
   localparam int BYTE_LSBS  = $clog2(BYTE_BITS);
   localparam int RESYNC_CYC = 2;

   localparam logic [5:0] LAST_BIT_CNT = 6'(FRAME_BITS);

   localparam int AXIS_W = 10;
   localparam int BTN_W  = 3;

   // Frame layout, MSB first: X low byte, X high bits, Y low byte, Y high bits, buttons.
   localparam int X_LO_MSB = 39;
   localparam int X_LO_LSB = 32;
   localparam int X_HI_MSB = 25;
   localparam int X_HI_LSB = 24;
   localparam int Y_LO_MSB = 23;
   localparam int Y_LO_LSB = 16;
   localparam int Y_HI_MSB = 9;
   localparam int Y_HI_LSB = 8;
   localparam int BTN_MSB  = 2;
   localparam int BTN_LSB  = 0;

   // True when the next bit to clock starts a new byte (8, 16, 24, 32), so the
   // inter-byte gap must be inserted before its ce.
   function automatic logic byte_gap(input logic [5:0] bit_cnt);
      return (bit_cnt[BYTE_LSBS-1:0] == '0) && (bit_cnt != '0) && (bit_cnt != LAST_BIT_CNT);
   endfunction

endpackage

// File: rtl/jstk_frame_decode.sv
// jstk_frame_decode: registered decode of the receiver's 40-bit DOUT into X/Y/buttons.
// Latency: 1 clk from load_i to updated outputs; valid_o pulses in that cycle.
// Backpressure: none; outputs hold their last decoded values between loads.
// Ports: clk/rst (sync, active-high); load_i capture strobe; dout_i frame;
//        x_o/y_o/btn_o decoded fields; valid_o one-cycle update pulse.
module jstk_frame_decode
   import spi_poll_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic [FRAME_BITS-1:0] dout_i,
   output logic [AXIS_W-1:0]     x_o,
   output logic [AXIS_W-1:0]     y_o,
   output logic [BTN_W-1:0]      btn_o,
   output logic                  valid_o
);

   logic [AXIS_W-1:0] x_q;
   logic [AXIS_W-1:0] y_q;
   logic [BTN_W-1:0]  btn_q;
   logic              valid_q;

   // Padding bits of the frame carry no information.
   logic unused_dout;
   assign unused_dout = ^{dout_i[31:26], dout_i[15:10], dout_i[7:3]};

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q     <= '0;
         y_q     <= '0;
         btn_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= load_i;
         if (load_i) begin
            x_q   <= {dout_i[X_HI_MSB:X_HI_LSB], dout_i[X_LO_MSB:X_LO_LSB]};
            y_q   <= {dout_i[Y_HI_MSB:Y_HI_LSB], dout_i[Y_LO_MSB:Y_LO_LSB]};
            btn_q <= dout_i[BTN_MSB:BTN_LSB];
         end
      end
   end

   assign x_o     = x_q;
   assign y_o     = y_q;
   assign btn_o   = btn_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/spi_poll_sched.sv
// spi_poll_sched: paces the 5-byte SPI receiver by issuing its 42 ce strobes
// (Init, 40 bits, Done) once per poll period, then decodes the captured frame.
// Latency: Init ce to frame_valid = SETUP_CYC + 40*BIT_CYC + 4*GAP_CYC + 3 clocks.
// Backpressure: none; enable low lets the running frame finish, then holds in IDLE.
// Ports: clk/rst (sync, active-high); enable; ss_in/dout_in from the receiver;
//        ce/spi_rst to the receiver; x/y/btn/frame_valid decoded frame; sync_err sticky.
module spi_poll_sched
   import spi_poll_pkg::*;
#(
   parameter int POLL_CYC  = 1_000_000,
   parameter int SETUP_CYC = 1500,
   parameter int BIT_CYC   = 100,
   parameter int GAP_CYC   = 1000
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  ss_in,
   input  logic [FRAME_BITS-1:0] dout_in,
   output logic                  ce,
   output logic                  spi_rst,
   output logic [AXIS_W-1:0]     x,
   output logic [AXIS_W-1:0]     y,
   output logic [BTN_W-1:0]      btn,
   output logic                  frame_valid,
   output logic                  sync_err
);

   // POLL_CYC is guaranteed to be the largest count, so one width covers all timers.
   localparam int CW        = $clog2(POLL_CYC);
   localparam int FRAME_LEN = SETUP_CYC + FRAME_BITS * BIT_CYC
                            + (FRAME_BITS / BYTE_BITS - 1) * GAP_CYC + 3;

   localparam logic [CW-1:0] POLL_LAST   = CW'(POLL_CYC - 1);
   localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] BIT_LAST    = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] GAP_LAST    = CW'(BIT_CYC + GAP_CYC - 1);
   localparam logic [CW-1:0] RESYNC_LAST = CW'(RESYNC_CYC - 1);

   if (POLL_CYC <= FRAME_LEN || BIT_CYC < 2 || SETUP_CYC < 2 || GAP_CYC < 0) begin : g_param_check
      $error("spi_poll_sched: need POLL_CYC > frame length, BIT_CYC >= 2, SETUP_CYC >= 2, GAP_CYC >= 0");
   end

   state_e          state_q, state_d;
   logic [CW-1:0]   poll_q, poll_d;
   logic [CW-1:0]   tmr_q, tmr_d;
   logic [5:0]      bit_cnt_q, bit_cnt_d;
   logic            sync_err_q;
   logic            rst_dly_q;

   logic            poll_wrap;
   logic            bit_done;
   logic            ce_raw;
   logic            capture;
   logic            resync_act;

   // Poll counter free-runs regardless of state so the frame period is exact.
   assign poll_wrap = (poll_q == POLL_LAST);
   assign poll_d    = poll_wrap ? '0 : poll_q + 1'b1;

   // Bit slot ends after BIT_CYC clocks, stretched by GAP_CYC ahead of a new byte.
   assign bit_done  = (tmr_q == (byte_gap(bit_cnt_q) ? GAP_LAST : BIT_LAST));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         poll_q     <= '0;
         tmr_q      <= '0;
         bit_cnt_q  <= '0;
         sync_err_q <= 1'b0;
         rst_dly_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         poll_q     <= poll_d;
         tmr_q      <= tmr_d;
         bit_cnt_q  <= bit_cnt_d;
         sync_err_q <= sync_err_q | (state_d == RESYNC);
         rst_dly_q  <= 1'b0;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q + 1'b1;
      bit_cnt_d = bit_cnt_q;
      case (state_q)
         IDLE: begin
            tmr_d     = '0;
            bit_cnt_d = '0;
            if (poll_wrap && enable) state_d = SETUP;
         end
         SETUP: begin
            if (tmr_q == SETUP_LAST) begin
               tmr_d = '0;
               // SS still high means the receiver never saw Init.
               if (ss_in) begin
                  state_d = RESYNC;
               end else begin
                  state_d   = BIT;
                  bit_cnt_d = 6'd1;
               end
            end
         end
         BIT: begin
            if (bit_done) begin
               tmr_d = '0;
               if (bit_cnt_q == LAST_BIT_CNT) state_d = FINISH;
               else                           bit_cnt_d = bit_cnt_q + 6'd1;
            end
         end
         FINISH: begin
            tmr_d   = '0;
            // Receiver raises SS on bit 39; low here means it lost count.
            state_d = ss_in ? CAPTURE : RESYNC;
         end
         CAPTURE: begin
            tmr_d     = '0;
            bit_cnt_d = '0;
            state_d   = IDLE;
         end
         RESYNC: begin
            if (tmr_q == RESYNC_LAST) begin
               tmr_d     = '0;
               bit_cnt_d = '0;
               state_d   = IDLE;
            end
         end
         default: begin
            tmr_d     = '0;
            bit_cnt_d = '0;
            state_d   = IDLE;
         end
      endcase
   end

   // Output logic
   always_comb begin
      ce_raw     = 1'b0;
      capture    = 1'b0;
      resync_act = 1'b0;
      case (state_q)
         IDLE:    ce_raw     = poll_wrap & enable;
         SETUP:   ce_raw     = (tmr_q == SETUP_LAST) & ~ss_in;
         BIT:     ce_raw     = bit_done & (bit_cnt_q != LAST_BIT_CNT);
         FINISH:  ce_raw     = ss_in;
         CAPTURE: capture    = 1'b1;
         RESYNC:  resync_act = 1'b1;
         default: ce_raw     = 1'b0;
      endcase
   end

   // rst gates ce in the same cycle so a reset never lets a stray strobe out.
   assign ce       = ce_raw & ~rst;
   // Receiver reset spans the reset cycle plus one, and every RESYNC cycle.
   assign spi_rst  = rst | rst_dly_q | resync_act;
   assign sync_err = sync_err_q;

   jstk_frame_decode u_decode (
      .clk     (clk),
      .rst     (rst),
      .load_i  (capture),
      .dout_i  (dout_in),
      .x_o     (x),
      .y_o     (y),
      .btn_o   (btn),
      .valid_o (frame_valid)
   );

endmodule

// File: tb/tb_spi_poll_sched.sv
// tb_spi_poll_sched: directed bench for spi_poll_sched with a behavioural
// 5-byte SPI receiver model; checks ce timing, decode, resync, enable and reset.
module tb_spi_poll_sched;

   localparam int POLL  = 400;
   localparam int SETUP = 4;
   localparam int BITC  = 3;
   localparam int GAP   = 5;
   localparam int LAT   = SETUP + 40 * BITC + 4 * GAP + 3;   // 147

   localparam logic [39:0] DATA_A = 40'hA5_02_3C_01_05;
   localparam logic [39:0] DATA_B = 40'h5A_01_C3_02_02;
   localparam logic [39:0] DATA_C = 40'h12_03_34_00_07;
   localparam logic [39:0] DATA_D = 40'hFF_00_00_03_00;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b1;
   logic        ss_in = 1'b1;
   logic [39:0] dout_in = '0;
   logic        ce;
   logic        spi_rst;
   logic [9:0]  x;
   logic [9:0]  y;
   logic [2:0]  btn;
   logic        frame_valid;
   logic        sync_err;

   always #5 clk = ~clk;

   spi_poll_sched #(
      .POLL_CYC  (POLL),
      .SETUP_CYC (SETUP),
      .BIT_CYC   (BITC),
      .GAP_CYC   (GAP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .ss_in       (ss_in),
      .dout_in     (dout_in),
      .ce          (ce),
      .spi_rst     (spi_rst),
      .x           (x),
      .y           (y),
      .btn         (btn),
      .frame_valid (frame_valid),
      .sync_err    (sync_err)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Receiver model: Init drops SS, bits shift MSB first, bit 39 raises SS, Done updates DOUT.
   logic [39:0] mdata = DATA_A;
   logic [39:0] sr_m = '0;
   bit          hold_low = 1'b0;
   int          mcnt = 0;

   always @(negedge clk) begin
      if (spi_rst) begin
         mcnt  = 0;
         ss_in = 1'b1;
      end else if (ce) begin
         if (mcnt == 0) begin
            ss_in = 1'b0;
         end else if (mcnt <= 40) begin
            sr_m = {sr_m[38:0], mdata[40 - mcnt]};
            if (mcnt == 40 && !hold_low) ss_in = 1'b1;
         end else begin
            dout_in = sr_m;
         end
         mcnt = (mcnt >= 41) ? 0 : mcnt + 1;
      end
   end

   // Monitors: ce timestamps, spi_rst cycles, frame_valid pulses, output stability.
   int          ce_log[$];
   int          n_srst = 0;
   int          n_fv = 0;
   int          fv_cyc = 0;
   int          n_viol = 0;
   logic [22:0] prev_out = '0;

   always @(negedge clk) begin
      if (ce) ce_log.push_back(cyc);
      if (spi_rst) n_srst++;
      if (frame_valid) begin
         n_fv++;
         fv_cyc = cyc;
      end
      if (!rst && ({x, y, btn} != prev_out) && !frame_valid) n_viol++;
      prev_out = {x, y, btn};
   end

   int ce_base = 0;

   function automatic int ce_cnt();
      return ce_log.size() - ce_base;
   endfunction

   function automatic int ce_at(input int k);
      return ce_log[ce_base + k];
   endfunction

   task automatic wait_ce(input int n, input int budget, input string tag);
      int i;
      i = 0;
      while (ce_cnt() < n && i < budget) begin
         @(posedge clk); #1;
         i++;
      end
      check({tag, " ce reached"}, 64'(ce_cnt() >= n), 64'd1);
   endtask

   task automatic wait_fv(input int budget, input string tag);
      int i;
      int start;
      i = 0;
      start = n_fv;
      while (n_fv == start && i < budget) begin
         @(posedge clk); #1;
         i++;
      end
      check({tag, " fv seen"}, 64'(n_fv - start), 64'd1);
      check({tag, " fv one cycle"}, 64'(frame_valid), 64'd0);
   endtask

   int c0;
   int t_c;
   int fv_before;
   int srst_base;

   initial begin
      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      #1;
      check("rst ce", 64'(ce), 64'd0);
      check("rst spi_rst", 64'(spi_rst), 64'd1);
      check("rst x", 64'(x), 64'd0);
      check("rst y", 64'(y), 64'd0);
      check("rst btn", 64'(btn), 64'd0);
      check("rst frame_valid", 64'(frame_valid), 64'd0);
      check("rst sync_err", 64'(sync_err), 64'd0);
      rst = 1'b0;
      c0  = cyc;
      #1;
      check("spi_rst cycle after rst", 64'(spi_rst), 64'd1);
      @(posedge clk); #1;
      check("spi_rst released", 64'(spi_rst), 64'd0);

      // ---------------- test 1/2: frame timing and decode ----------------
      wait_ce(1, 450, "t1 first");
      if (ce_cnt() > 0) check("t1 first ce cycle", 64'(ce_at(0) - c0), 64'(POLL - 1));
      wait_fv(300, "t1");
      check("t1 ce per frame", 64'(ce_cnt()), 64'd42);
      if (ce_cnt() >= 42) begin
         check("t1 init->bit0 gap", 64'(ce_at(1) - ce_at(0)), 64'(SETUP));
         for (int k = 1; k <= 39; k++) begin
            check($sformatf("t1 gap before bit %0d", k), 64'(ce_at(k + 1) - ce_at(k)),
                  64'((k % 8 == 0) ? BITC + GAP : BITC));
         end
         check("t1 bit39->done gap", 64'(ce_at(41) - ce_at(40)), 64'(BITC + 1));
         check("t1 init->fv latency", 64'(fv_cyc - ce_at(0)), 64'(LAT));
         check("t1 done->fv", 64'(fv_cyc - ce_at(41)), 64'd2);
      end
      check("t2 x", 64'(x), 64'h2A5);
      check("t2 y", 64'(y), 64'h13C);
      check("t2 btn", 64'(btn), 64'b101);

      // ---------------- test 3: SS stuck low -> resync ----------------
      hold_low  = 1'b1;
      ce_base   = ce_log.size();
      srst_base = n_srst;
      fv_before = n_fv;
      wait_ce(41, 500, "t3 bits");
      repeat (6) @(posedge clk);
      #1;
      check("t3 no done ce", 64'(ce_cnt()), 64'd41);
      check("t3 spi_rst cycles", 64'(n_srst - srst_base), 64'd2);
      check("t3 sync_err set", 64'(sync_err), 64'd1);
      check("t3 no frame_valid", 64'(n_fv - fv_before), 64'd0);
      check("t3 x kept", 64'(x), 64'h2A5);
      hold_low = 1'b0;
      mdata    = DATA_B;
      wait_fv(500, "t3 next");
      check("t3 next x", 64'(x), 64'h15A);
      check("t3 next y", 64'(y), 64'h2C3);
      check("t3 next btn", 64'(btn), 64'b010);
      check("t3 sync_err sticky", 64'(sync_err), 64'd1);

      // ---------------- test 4: enable drop mid-frame ----------------
      ce_base = ce_log.size();
      wait_ce(22, 500, "t4 bit20");
      enable = 1'b0;
      wait_fv(300, "t4 finish");
      check("t4 frame completed", 64'(ce_cnt()), 64'd42);
      ce_base = ce_log.size();
      repeat (3 * POLL) @(posedge clk);
      #1;
      check("t4 idle no ce", 64'(ce_cnt()), 64'd0);
      enable = 1'b1;
      wait_ce(1, 450, "t4 resume");
      if (ce_cnt() > 0) check("t4 resume on wrap", 64'((ce_at(0) - c0) % POLL), 64'(POLL - 1));

      // ---------------- test 5: rst mid-frame ----------------
      wait_ce(19, 200, "t5 bit17");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("t5 ce gated by rst", 64'(ce), 64'd0);
      check("t5 spi_rst in rst", 64'(spi_rst), 64'd1);
      ce_base = ce_log.size();
      @(posedge clk); #1;
      check("t5 x cleared", 64'(x), 64'd0);
      check("t5 y cleared", 64'(y), 64'd0);
      check("t5 btn cleared", 64'(btn), 64'd0);
      check("t5 sync_err cleared", 64'(sync_err), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      check("t5 no ce during rst", 64'(ce_cnt()), 64'd0);
      rst = 1'b0;
      c0  = cyc;
      wait_ce(1, 450, "t5 restart");
      if (ce_cnt() > 0) check("t5 first ce after rst", 64'(ce_at(0) - c0), 64'(POLL - 1));
      wait_fv(300, "t5 frame");
      check("t5 x", 64'(x), 64'h15A);
      check("t5 btn", 64'(btn), 64'b010);

      // ---------------- test 6: back-to-back frames ----------------
      mdata = DATA_C;
      wait_fv(500, "t6 frame C");
      t_c = fv_cyc;
      check("t6 C x", 64'(x), 64'h312);
      check("t6 C y", 64'(y), 64'h034);
      check("t6 C btn", 64'(btn), 64'b111);
      mdata = DATA_D;
      wait_fv(500, "t6 frame D");
      check("t6 D x", 64'(x), 64'h0FF);
      check("t6 D y", 64'(y), 64'h300);
      check("t6 D btn", 64'(btn), 64'b000);
      check("t6 fv period", 64'(fv_cyc - t_c), 64'(POLL));
      check("t6 outputs change only on fv", 64'(n_viol), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
